// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// axi_lite_master : single-outstanding AXI4-Lite master behind a valid/ready
//                   request port, reporting data, error and latency per access
// Revision: 1.0
// ============================================================================
module axi_lite_master #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [AXI_AWIDTH-1:0]   REQ_ADDR,
  input  logic [AXI_DWIDTH-1:0]   REQ_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] REQ_WSTRB,
  output logic                    RSP_VALID,
  output logic [AXI_DWIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [15:0]             RSP_LATENCY,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [AXI_AWIDTH-1:0]     addr_q;
  logic [AXI_DWIDTH-1:0]     wdata_q;
  logic [AXI_DWIDTH/8-1:0]   wstrb_q;
  logic                      aw_done, w_done;
  logic [15:0]               lat_cnt;
  logic [15:0]               lat_inc;
  logic                      txn_end;
  logic [1:0]                resp_code;
  logic                      rsp_valid_q, rsp_err_q;
  logic [AXI_DWIDTH-1:0]     rsp_rdata_q;
  logic [15:0]               rsp_latency_q;

  assign AXI_AWADDR  = addr_q;
  assign AXI_ARADDR  = addr_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_LATENCY = rsp_latency_q;
  assign lat_inc     = (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    REQ_READY   = 1'b0;
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    AXI_BREADY  = 1'b0;
    AXI_ARVALID = 1'b0;
    AXI_RREADY  = 1'b0;
    txn_end     = 1'b0;
    resp_code   = 2'b00;
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_nxt = REQ_WE ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        // AW and W retire independently; leave once both have completed
        AXI_AWVALID = !aw_done;
        AXI_WVALID  = !w_done;
        if ((aw_done || AXI_AWREADY) && (w_done || AXI_WREADY)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        AXI_BREADY = 1'b1;
        if (AXI_BVALID) begin
          txn_end   = 1'b1;
          resp_code = AXI_BRESP;
          state_nxt = IDLE;
        end
      end
      RD_REQ: begin
        AXI_ARVALID = 1'b1;
        if (AXI_ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        AXI_RREADY = 1'b1;
        if (AXI_RVALID) begin
          txn_end   = 1'b1;
          resp_code = AXI_RRESP;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      lat_cnt       <= 16'd0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_latency_q <= 16'd0;
    end else begin
      // lat_cnt counts the acceptance edge as 1
      if (state == IDLE && REQ_VALID) begin
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        wstrb_q <= REQ_WSTRB;
        lat_cnt <= 16'd1;
      end else if (state != IDLE) begin
        lat_cnt <= lat_inc;
      end

      if (state == WR_REQ) begin
        if (AXI_AWVALID && AXI_AWREADY) aw_done <= 1'b1;
        if (AXI_WVALID && AXI_WREADY)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      rsp_valid_q <= txn_end;
      if (txn_end) begin
        rsp_err_q     <= resp_code[1];
        rsp_rdata_q   <= (state == RD_DATA) ? AXI_RDATA : '0;
        rsp_latency_q <= lat_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_master : scoreboard bench with a delay-programmable AXI-Lite slave
// Revision: 1.0
// ============================================================================
module tb_axi_lite_master;

  logic        AXI_ACLK = 1'b0;
  logic        AXI_ARESETN;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [3:0]  REQ_WSTRB;
  logic        RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [15:0] RSP_LATENCY;
  logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
  logic        AXI_RVALID, AXI_RREADY;

  always #5 AXI_ACLK = ~AXI_ACLK;

  axi_lite_master #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .RSP_LATENCY(RSP_LATENCY),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID),
    .AXI_BREADY(AXI_BREADY), .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID),
    .AXI_ARREADY(AXI_ARREADY), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  strb;
    int          da, dw, dd;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_lat;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   rsp_cnt = 0;
  logic overlap_seen = 1'b0;
  logic spurious = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // da: AW/AR ready delay, dw: W ready delay, dd: B/R valid delay
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int da, input int dw, input int dd,
                      input logic [1:0] resp, input logic [31:0] rdata);
    txn_t t;
    int   l, n;
    logic acc;
    t.we = we; t.addr = addr; t.wdata = wdata; t.strb = strb; t.rdata = rdata;
    t.da = da; t.dw = dw; t.dd = dd; t.resp = resp;
    l = we ? 3 + ((da > dw) ? da : dw) + dd : 3 + da + dd;
    t.exp_lat   = (l > 65535) ? 16'hFFFF : 16'(l);
    t.exp_rdata = we ? 32'h0 : rdata;
    t.exp_err   = resp[1];
    sb.push_back(t);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_WSTRB = strb;
    acc = 1'b0; n = 0;
    while (!acc && n < 1000) begin
      if (REQ_READY) acc = 1'b1;
      @(negedge AXI_ACLK);
      n++;
    end
    if (!acc) check("req_accept_timeout", 0, 1);
    REQ_VALID = 1'b0; REQ_WE = $urandom_range(0, 1);
    REQ_ADDR = $urandom; REQ_WDATA = $urandom; REQ_WSTRB = 4'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge AXI_ACLK);
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", 0, 1);
      sb.delete();
    end
    repeat (2) @(negedge AXI_ACLK);
  endtask

  // Monitor + slave model, evaluated once per cycle on the falling edge
  initial begin
    txn_t        t;
    logic        has;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    logic [3:0]  p_wstrb = 0;
    logic        aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic [48:0] last_rsp = '0;
    AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0; AXI_BVALID = 0; AXI_BRESP = 0;
    AXI_RVALID = 0; AXI_RRESP = 0; AXI_RDATA = 0;
    forever begin
      @(negedge AXI_ACLK);
      if (!AXI_ARESETN) begin
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0; AXI_BVALID = 0; AXI_RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; last_rsp = '0;
      end else begin
        if (p_awv && p_awr) aw_hs = 1;
        if (p_wv && p_wr)   w_hs = 1;
        if (p_arv && p_arr) ar_hs = 1;
        if (p_awv && !p_awr) begin
          check("awvalid_hold", AXI_AWVALID, 1);
          check("awaddr_stable", AXI_AWADDR, p_awaddr);
        end
        if (p_awv && p_awr) check("awvalid_drop", AXI_AWVALID, 0);
        if (p_wv && !p_wr) begin
          check("wvalid_hold", AXI_WVALID, 1);
          check("wdata_stable", {AXI_WSTRB, AXI_WDATA}, {p_wstrb, p_wdata});
        end
        if (p_wv && p_wr) check("wvalid_drop", AXI_WVALID, 0);
        if (p_arv && !p_arr) begin
          check("arvalid_hold", AXI_ARVALID, 1);
          check("araddr_stable", AXI_ARADDR, p_araddr);
        end
        if (p_arv && p_arr) check("arvalid_drop", AXI_ARVALID, 0);
        if (AXI_BREADY) check("bready_early", {aw_hs, w_hs}, 2'b11);
        if (AXI_RREADY) check("rready_early", ar_hs, 1);

        if (RSP_VALID) begin
          if (sb.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            t = sb.pop_front();
            check("rsp_rdata", RSP_RDATA, t.exp_rdata);
            check("rsp_err", RSP_ERR, t.exp_err);
            check("rsp_latency", RSP_LATENCY, t.exp_lat);
          end
          rsp_cnt++;
          if (REQ_VALID && REQ_READY) overlap_seen = 1'b1;
          aw_hs = 0; w_hs = 0; ar_hs = 0;
          last_rsp = {RSP_ERR, RSP_LATENCY, RSP_RDATA};
        end else begin
          check("rsp_hold", {RSP_ERR, RSP_LATENCY, RSP_RDATA}, last_rsp);
        end

        has = (sb.size() != 0);
        if (has) t = sb[0];
        AXI_AWREADY = has && AXI_AWVALID && aw_cnt >= t.da;
        aw_cnt      = AXI_AWVALID ? aw_cnt + 1 : 0;
        if (AXI_AWVALID && AXI_AWREADY) check("aw_addr", AXI_AWADDR, t.addr);
        AXI_WREADY  = has && AXI_WVALID && w_cnt >= t.dw;
        w_cnt       = AXI_WVALID ? w_cnt + 1 : 0;
        if (AXI_WVALID && AXI_WREADY) check("w_data", {AXI_WSTRB, AXI_WDATA}, {t.strb, t.wdata});
        AXI_ARREADY = has && AXI_ARVALID && ar_cnt >= t.da;
        ar_cnt      = AXI_ARVALID ? ar_cnt + 1 : 0;
        if (AXI_ARVALID && AXI_ARREADY) check("ar_addr", AXI_ARADDR, t.addr);
        AXI_BVALID  = spurious || (has && AXI_BREADY && b_cnt >= t.dd);
        AXI_BRESP   = has ? t.resp : 2'b10;
        b_cnt       = AXI_BREADY ? b_cnt + 1 : 0;
        AXI_RVALID  = spurious || (has && AXI_RREADY && r_cnt >= t.dd);
        AXI_RRESP   = has ? t.resp : 2'b11;
        AXI_RDATA   = has ? t.rdata : 32'hBAD0_BAD0;
        r_cnt       = AXI_RREADY ? r_cnt + 1 : 0;

        p_awv = AXI_AWVALID; p_awr = AXI_AWREADY; p_awaddr = AXI_AWADDR;
        p_wv  = AXI_WVALID;  p_wr  = AXI_WREADY;  p_wdata  = AXI_WDATA; p_wstrb = AXI_WSTRB;
        p_arv = AXI_ARVALID; p_arr = AXI_ARREADY; p_araddr = AXI_ARADDR;
      end
    end
  end

  initial begin
    int n;
    int cnt0;
    AXI_ARESETN = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0;
    REQ_ADDR = 32'h0; REQ_WDATA = 32'h0; REQ_WSTRB = 4'h0;
    repeat (3) @(negedge AXI_ACLK);
    check("rst_axi_valids", {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 5'b0);
    check("rst_rsp", {RSP_VALID, RSP_ERR, RSP_LATENCY, RSP_RDATA}, 50'h0);
    check("rst_regs", {AXI_AWADDR, AXI_WDATA, AXI_WSTRB}, 68'h0);
    AXI_ARESETN = 1'b1;
    @(negedge AXI_ACLK);
    check("req_ready_after_rst", REQ_READY, 1);

    // zero-wait write
    send(1'b1, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    wait_done(100);
    check("zero_wait_latency", RSP_LATENCY, 16'd3);
    // split AW/W handshake
    send(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h5, 0, 3, 0, 2'b00, 32'h0);
    wait_done(100);
    // read with error response
    send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 2, 0, 4, 2'b10, 32'h1234_5678);
    wait_done(100);
    check("read_err_latency", RSP_LATENCY, 16'd9);
    check("read_err_flag", RSP_ERR, 1);
    // further response codes and skews
    send(1'b1, 32'h0000_0080, 32'h0102_0304, 4'h3, 3, 1, 2, 2'b11, 32'h0);
    wait_done(100);
    send(1'b1, 32'h0000_0084, 32'hFFFF_0000, 4'hC, 1, 4, 0, 2'b01, 32'h0);
    wait_done(100);
    send(1'b0, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 2'b01, 32'hA5A5_5A5A);
    wait_done(100);
    for (int i = 0; i < 4; i++) begin
      send(1'(i % 2), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom);
      wait_done(100);
    end

    // back-to-back write then read
    cnt0 = rsp_cnt; overlap_seen = 1'b0;
    send(1'b1, 32'h0000_3000, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    send(1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h7777_8888);
    wait_done(100);
    repeat (3) @(negedge AXI_ACLK);
    check("b2b_rsp_count", rsp_cnt - cnt0, 2);
    check("b2b_overlap", overlap_seen, 1);

    // stray B/R valids while idle must not produce a response
    spurious = 1'b1;
    repeat (3) @(negedge AXI_ACLK);
    spurious = 1'b0;
    repeat (2) @(negedge AXI_ACLK);

    // reset while waiting for B
    send(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'hF, 0, 0, 1000, 2'b00, 32'h0);
    n = 0;
    while (!AXI_BREADY && n < 50) begin
      @(negedge AXI_ACLK);
      n++;
    end
    check("reached_wr_resp", AXI_BREADY, 1);
    AXI_ARESETN = 1'b0;
    sb.delete();
    @(negedge AXI_ACLK);
    check("midrst_valids", {AXI_AWVALID, AXI_WVALID, AXI_BREADY}, 3'b000);
    check("midrst_rsp", {RSP_VALID, RSP_LATENCY}, 17'h0);
    @(negedge AXI_ACLK);
    AXI_ARESETN = 1'b1;
    @(negedge AXI_ACLK);
    check("midrst_req_ready", REQ_READY, 1);
    cnt0 = rsp_cnt;
    repeat (5) @(negedge AXI_ACLK);
    check("midrst_no_rsp", rsp_cnt - cnt0, 0);

    // latency saturation
    send(1'b1, 32'h0000_5000, 32'h0BAD_CAFE, 4'hF, 0, 0, 70000, 2'b00, 32'h0);
    wait_done(80000);
    check("sat_latency", RSP_LATENCY, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 32, meaning address width of the request and AXI address buses.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, meaning data width; the strobe width is AXI_DWIDTH/8.
REQ-003 SHALL use one clock and a synchronous active-low reset: AXI_ACLK in 1 (clock); AXI_ARESETN in 1 (sync reset, active low).
REQ-004 SHALL provide the request ports: REQ_VALID in 1; REQ_READY out 1; REQ_WE in 1 (1=write, 0=read); REQ_ADDR in AXI_AWIDTH; REQ_WDATA in AXI_DWIDTH; REQ_WSTRB in AXI_DWIDTH/8.
REQ-005 SHALL provide the response ports: RSP_VALID out 1 (one-cycle pulse); RSP_RDATA out AXI_DWIDTH; RSP_ERR out 1; RSP_LATENCY out 16 (cycle count).
REQ-006 SHALL provide the write-address and write-data channels: AXI_AWADDR out AXI_AWIDTH; AXI_AWVALID out 1; AXI_AWREADY in 1; AXI_WDATA out AXI_DWIDTH; AXI_WSTRB out AXI_DWIDTH/8; AXI_WVALID out 1; AXI_WREADY in 1.
REQ-007 SHALL provide the write-response channel: AXI_BRESP in 2; AXI_BVALID in 1; AXI_BREADY out 1.
REQ-008 SHALL provide the read channels: AXI_ARADDR out AXI_AWIDTH; AXI_ARVALID out 1; AXI_ARREADY in 1; AXI_RDATA in AXI_DWIDTH; AXI_RRESP in 2; AXI_RVALID in 1; AXI_RREADY out 1.

Function
REQ-009 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ and RD_DATA, with one outstanding transaction at most.
REQ-010 SHALL drive REQ_READY=1 only in IDLE; a request SHALL be accepted on a clock edge where REQ_VALID&&REQ_READY.
REQ-011 SHALL, on acceptance, register the address, wdata and wstrb, and SHALL enter WR_REQ if REQ_WE=1, else RD_REQ.
REQ-012 SHALL drive AXI_AWADDR/AXI_ARADDR/AXI_WDATA/AXI_WSTRB from the registered values only; these outputs SHALL be stable while the corresponding VALID is high.
REQ-013 SHALL, in WR_REQ, assert AXI_AWVALID and AXI_WVALID from the first cycle; each SHALL remain high until its own handshake (VALID&&READY at an edge) and then drop independently.
REQ-014 SHALL leave WR_REQ for WR_RESP on the edge where the later of the AW and W handshakes completes; simultaneous AW and W handshakes SHALL complete in a single cycle.
REQ-015 SHALL assert AXI_BREADY=1 only in WR_RESP; the edge with AXI_BVALID=1 SHALL end the transaction.
REQ-016 SHALL, in RD_REQ, assert AXI_ARVALID until the AR handshake, then enter RD_DATA.
REQ-017 SHALL assert AXI_RREADY=1 only in RD_DATA; the edge with AXI_RVALID=1 SHALL capture AXI_RDATA and end the transaction.
REQ-018 SHALL, at transaction end, pulse RSP_VALID high for exactly the next cycle and return to IDLE in that same cycle, so that a new request can be accepted while RSP_VALID=1.
REQ-019 SHALL set RSP_ERR=1 when the BRESP/RRESP value is 2'b10 or 2'b11, else RSP_ERR=0.
REQ-020 SHALL set RSP_RDATA to the captured RDATA for reads and to 0 for writes; RSP_RDATA, RSP_ERR and RSP_LATENCY SHALL hold their values until the next RSP_VALID.
REQ-021 SHALL set RSP_LATENCY to the number of clock edges from request acceptance to the edge that raises RSP_VALID, saturating at 16'hFFFF; the minimum value is 3 for zero-wait-state writes and reads.
REQ-022 SHALL ignore AXI_BVALID and AXI_RVALID outside WR_RESP and RD_DATA respectively, and SHALL ignore REQ_* outside IDLE.

Reset
REQ-023 SHALL, while AXI_ARESETN=0 at a clock edge, set state=IDLE, all AXI VALID/READY outputs=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, RSP_LATENCY=0, and registered addr/data/strb=0.
REQ-024 SHALL discard any in-flight transaction on reset and SHALL NOT produce RSP_VALID for it; REQ_READY SHALL be 1 on the first cycle after reset is released.

Verification
REQ-025 SHALL pass a zero-wait write: REQ write addr 0xF0000000, data 0xDEADBEEF, strb 0xF, with AWREADY=WREADY=1 and BVALID immediate -> AW/W handshake in cycle 1, B handshake in cycle 2, RSP_VALID in cycle 3 with RSP_ERR=0 and RSP_LATENCY=3.
REQ-026 SHALL pass a split handshake: AWREADY high at cycle 1, WREADY high at cycle 4 -> AWVALID low from cycle 2, WVALID held through cycle 4, BREADY high from cycle 5, AWADDR/WDATA stable throughout.
REQ-027 SHALL pass a read error: read at 0x00001000, ARREADY after 2 cycles, RVALID after 5 more cycles with RDATA 0x12345678 and RRESP 2'b10 -> RSP_RDATA=0x12345678, RSP_ERR=1, RSP_LATENCY=9.
REQ-028 SHALL pass back-to-back requests: REQ_VALID held with write then read queued -> second request accepted in the RSP_VALID cycle of the first, and exactly two RSP_VALID pulses are produced.
REQ-029 SHALL pass reset mid-transaction: AXI_ARESETN=0 in WR_RESP with BVALID withheld -> the next edge has AWVALID=WVALID=BREADY=0 and RSP_VALID never asserted, and REQ_READY=1 after release.
REQ-030 SHALL pass latency saturation: BVALID withheld for 70000 cycles -> RSP_LATENCY=16'hFFFF.
